// File: rtl/hdlc_pkg.sv
// hdlc_pkg - shared types and sizing constants for the HDLC frame buffers.
//   rx_state_t   : RX buffer FSM states
//   RX_MAX_BYTES : RX storage depth in bytes, FCS included
//   FCS_BYTES    : trailing FCS bytes excluded from the reported frame size
//   RX_MIN_BYTES : smallest stored byte count accepted as a frame
package hdlc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
  } rx_state_t;

  localparam logic [7:0] RX_MAX_BYTES = 8'd128;
  localparam logic [7:0] FCS_BYTES    = 8'd2;
  localparam logic [7:0] RX_MIN_BYTES = 8'd3;

endpackage

// File: rtl/rx_buff_mem.sv
// rx_buff_mem - 128x8 frame storage for the HDLC RX buffer.
//   Clk     : clock
//   Rst     : synchronous active-high reset, clears every location to 0
//   i_we    : write enable
//   i_waddr : write address
//   i_wdata : write data
//   i_raddr : read address
//   o_rdata : combinational read data at i_raddr
module rx_buff_mem (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       i_we,
  input  logic [6:0] i_waddr,
  input  logic [7:0] i_wdata,
  input  logic [6:0] i_raddr,
  output logic [7:0] o_rdata
);

  logic [7:0] r_mem [128];

  always_ff @(posedge Clk) begin
    if (Rst) begin
      for (int i = 0; i < 128; i++) begin
        r_mem[i] <= 8'h00;
      end
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/rx_buff.sv
// rx_buff - HDLC receive-side frame buffer.
// The RX channel writes de-stuffed bytes (payload + FCS); a clean EoF commits
// the frame for the CPU to read byte by byte. Errored, aborted, runt or
// overflowed frames are discarded.
//
// Ports:
//   Clk, Rst     : clock, synchronous active-high reset
//   WrBuff       : RX write strobe, DataInBuff is the byte
//   EoF          : end-of-frame pulse, FrameError sampled with it
//   AbortSignal  : abort sequence received, beats a simultaneous EoF
//   RdBuff       : CPU read strobe
//   Drop         : (RX_BUFF_DROP_EN only) abandon the frame being read
//   DataOutBuff  : byte at the read pointer (combinational)
//   Ready        : committed frame available
//   FrameSize    : payload bytes of the committed frame
//   Overflow     : sticky, bytes were lost
//
// Build option: define RX_BUFF_DROP_EN to add the Drop input.
//
// state | meaning
// IDLE  | no frame; first WrBuff starts one at index 0
// WRITE | collecting bytes until EoF or abort
// READ  | committed frame held for the CPU, Ready = 1
module rx_buff
  import hdlc_pkg::*;
(
  input  logic       Clk,
  input  logic       Rst,
  input  logic       WrBuff,
  input  logic [7:0] DataInBuff,
  input  logic       EoF,
  input  logic       FrameError,
  input  logic       AbortSignal,
  input  logic       RdBuff,
`ifdef RX_BUFF_DROP_EN
  input  logic       Drop,
`endif
  output logic [7:0] DataOutBuff,
  output logic       Ready,
  output logic [7:0] FrameSize,
  output logic       Overflow
);

  rx_state_t  r_state;
  logic [7:0] r_wr_count;
  logic [7:0] r_rd_ptr;
  logic [7:0] r_frame_size;
  logic       r_overflow;

  logic       w_room;
  logic       w_we;
  logic [6:0] w_waddr;
  logic [7:0] w_eof_count;
  logic       w_eof_ovf;
  logic       w_last_rd;
  logic       w_drop;

  assign w_room  = (r_wr_count < RX_MAX_BYTES);
  assign w_we    = WrBuff && ((r_state == IDLE) || ((r_state == WRITE) && w_room));
  assign w_waddr = (r_state == IDLE) ? 7'd0 : r_wr_count[6:0];

  // EoF is judged on the count/overflow as they stand after a same-cycle write.
  assign w_eof_count = (WrBuff && w_room) ? (r_wr_count + 8'd1) : r_wr_count;
  assign w_eof_ovf   = r_overflow || (WrBuff && !w_room);

  assign w_last_rd = (r_rd_ptr == (r_frame_size - 8'd1));

`ifdef RX_BUFF_DROP_EN
  assign w_drop = Drop;
`else
  assign w_drop = 1'b0;
`endif

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state      <= IDLE;
      r_wr_count   <= 8'd0;
      r_rd_ptr     <= 8'd0;
      r_frame_size <= 8'd0;
      r_overflow   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (WrBuff) begin
            r_wr_count <= 8'd1;
            r_overflow <= 1'b0;
            r_state    <= WRITE;
          end
        end
        WRITE: begin
          if (WrBuff && !w_room) begin
            r_overflow <= 1'b1;
          end
          if (AbortSignal) begin
            r_wr_count <= 8'd0;
            r_state    <= IDLE;
          end else if (EoF) begin
            if (FrameError || w_eof_ovf || (w_eof_count < RX_MIN_BYTES)) begin
              r_wr_count <= 8'd0;
              r_state    <= IDLE;
            end else begin
              r_wr_count   <= w_eof_count;
              r_frame_size <= w_eof_count - FCS_BYTES;
              r_rd_ptr     <= 8'd0;
              r_state      <= READ;
            end
          end else if (WrBuff && w_room) begin
            r_wr_count <= r_wr_count + 8'd1;
          end
        end
        READ: begin
          if (WrBuff) begin
            r_overflow <= 1'b1;
          end
          if (w_drop || (RdBuff && w_last_rd)) begin
            r_rd_ptr   <= 8'd0;
            r_wr_count <= 8'd0;
            r_state    <= IDLE;
          end else if (RdBuff) begin
            r_rd_ptr <= r_rd_ptr + 8'd1;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  rx_buff_mem u_mem (
    .Clk     (Clk),
    .Rst     (Rst),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (DataInBuff),
    .i_raddr (r_rd_ptr[6:0]),
    .o_rdata (DataOutBuff)
  );

  assign Ready     = (r_state == READ);
  assign FrameSize = r_frame_size;
  assign Overflow  = r_overflow;

endmodule

// File: tb/tb_rx_buff.sv
// tb_rx_buff - scoreboard bench for rx_buff.
// Stimulus pushes expected frame sizes and read bytes into queues; a monitor
// pops them when Ready rises (size) and on each accepted read (data).
module tb_rx_buff;

  logic       Clk = 1'b0;
  logic       Rst = 1'b1;
  logic       WrBuff = 1'b0;
  logic [7:0] DataInBuff = 8'h00;
  logic       EoF = 1'b0;
  logic       FrameError = 1'b0;
  logic       AbortSignal = 1'b0;
  logic       RdBuff = 1'b0;
`ifdef RX_BUFF_DROP_EN
  logic       Drop = 1'b0;
`endif
  logic [7:0] DataOutBuff;
  logic       Ready;
  logic [7:0] FrameSize;
  logic       Overflow;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] q_size[$];
  logic [7:0] q_data[$];
  logic       prev_ready = 1'b0;

  rx_buff dut (
    .Clk         (Clk),
    .Rst         (Rst),
    .WrBuff      (WrBuff),
    .DataInBuff  (DataInBuff),
    .EoF         (EoF),
    .FrameError  (FrameError),
    .AbortSignal (AbortSignal),
    .RdBuff      (RdBuff),
`ifdef RX_BUFF_DROP_EN
    .Drop        (Drop),
`endif
    .DataOutBuff (DataOutBuff),
    .Ready       (Ready),
    .FrameSize   (FrameSize),
    .Overflow    (Overflow)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: frame commit and byte reads, sampled on the falling edge.
  always @(negedge Clk) begin
    if (!Rst) begin
      if (Ready && !prev_ready) begin
        if (q_size.size() == 0) begin
          check("unexpected_commit", 32'(FrameSize), 32'hFFFF_FFFF);
        end else begin
          check("frame_size", 32'(FrameSize), 32'(q_size.pop_front()));
        end
      end
      if (Ready && RdBuff) begin
        if (q_data.size() == 0) begin
          check("unexpected_read", 32'(DataOutBuff), 32'hFFFF_FFFF);
        end else begin
          check("read_data", 32'(DataOutBuff), 32'(q_data.pop_front()));
        end
      end
    end
    prev_ready <= Ready;
  end

  task automatic tick();
    @(posedge Clk);
    #1;
    WrBuff = 1'b0; EoF = 1'b0; FrameError = 1'b0; AbortSignal = 1'b0; RdBuff = 1'b0;
`ifdef RX_BUFF_DROP_EN
    Drop = 1'b0;
`endif
  endtask

  task automatic wr(input logic [7:0] b);
    WrBuff = 1'b1; DataInBuff = b;
    tick();
  endtask

  task automatic eof(input logic err);
    EoF = 1'b1; FrameError = err;
    tick();
  endtask

  task automatic rd(input logic [7:0] exp);
    q_data.push_back(exp);
    RdBuff = 1'b1;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    Rst = 1'b1;
    tick(); tick();
    Rst = 1'b0;
    tick();
    check("rst_ready", 32'(Ready), 32'd0);
    check("rst_size", 32'(FrameSize), 32'd0);
    check("rst_ovf", 32'(Overflow), 32'd0);
    check("rst_dout", 32'(DataOutBuff), 32'd0);

    // Valid frame: payload 11 22 33, FCS AA BB
    q_size.push_back(8'd3);
    wr(8'h11); wr(8'h22); wr(8'h33); wr(8'hAA); wr(8'hBB);
    check("ready_before_eof", 32'(Ready), 32'd0);
    eof(1'b0);
    check("ready_after_eof", 32'(Ready), 32'd1);
    rd(8'h11); rd(8'h22);
    check("ready_mid_read", 32'(Ready), 32'd1);
    rd(8'h33);
    check("ready_after_last", 32'(Ready), 32'd0);

    // FCS error on a 10-byte frame, then a clean 4-byte frame
    for (int i = 0; i < 10; i++) wr(8'(8'h40 + i));
    eof(1'b1);
    check("ready_fcs_err", 32'(Ready), 32'd0);
    q_size.push_back(8'd2);
    wr(8'h01); wr(8'h02); wr(8'h03); wr(8'h04);
    eof(1'b0);
    rd(8'h01); rd(8'h02);
    check("ready_after_f2", 32'(Ready), 32'd0);

    // Overflow: 130 writes
    for (int i = 0; i < 130; i++) wr(8'(i));
    check("ovf_set", 32'(Overflow), 32'd1);
    eof(1'b0);
    check("ovf_frame_dropped", 32'(Ready), 32'd0);
    check("ovf_sticky", 32'(Overflow), 32'd1);
    wr(8'h61);
    check("ovf_cleared", 32'(Overflow), 32'd0);
    // Abort beats EoF
    wr(8'h62); wr(8'h63); wr(8'h64); wr(8'h65);
    AbortSignal = 1'b1; EoF = 1'b1;
    tick();
    check("abort_dropped", 32'(Ready), 32'd0);
    tick();
    check("abort_stays_idle", 32'(Ready), 32'd0);

    // Write during READ sets Overflow, stored data unchanged
    q_size.push_back(8'd2);
    wr(8'hC1); wr(8'hC2); wr(8'hC3); wr(8'hC4);
    eof(1'b0);
    wr(8'hEE);
    check("ovf_in_read", 32'(Overflow), 32'd1);
    check("ready_after_wr_in_read", 32'(Ready), 32'd1);
    rd(8'hC1); rd(8'hC2);
    check("ready_after_f3", 32'(Ready), 32'd0);

    // Exactly 128 bytes: no overflow, FrameSize 126
    q_size.push_back(8'd126);
    for (int i = 0; i < 128; i++) wr(8'(8'hFF - i));
    check("full_no_ovf", 32'(Overflow), 32'd0);
    eof(1'b0);
    check("full_ready", 32'(Ready), 32'd1);
    for (int i = 0; i < 126; i++) rd(8'(8'hFF - i));
    check("full_done", 32'(Ready), 32'd0);

    // Runt: 2 bytes
    wr(8'h31); wr(8'h32);
    eof(1'b0);
    check("runt_dropped", 32'(Ready), 32'd0);

    // WrBuff and EoF together on the 3rd byte
    q_size.push_back(8'd1);
    wr(8'h5A); wr(8'h5B);
    WrBuff = 1'b1; DataInBuff = 8'h5C; EoF = 1'b1;
    tick();
    check("wr_eof_ready", 32'(Ready), 32'd1);
    rd(8'h5A);
    check("wr_eof_done", 32'(Ready), 32'd0);

    // Rst mid-read
    q_size.push_back(8'd3);
    wr(8'h71); wr(8'h72); wr(8'h73); wr(8'h74); wr(8'h75);
    eof(1'b0);
    wr(8'hEE);
    rd(8'h71);
    Rst = 1'b1;
    tick();
    Rst = 1'b0;
    check("rstmid_ready", 32'(Ready), 32'd0);
    check("rstmid_size", 32'(FrameSize), 32'd0);
    check("rstmid_ovf", 32'(Overflow), 32'd0);
    check("rstmid_dout", 32'(DataOutBuff), 32'd0);
    tick();

`ifdef RX_BUFF_DROP_EN
    q_size.push_back(8'd5);
    for (int i = 0; i < 7; i++) wr(8'(8'h81 + i));
    eof(1'b0);
    rd(8'h81);
    Drop = 1'b1;
    tick();
    check("drop_ready", 32'(Ready), 32'd0);
    q_size.push_back(8'd1);
    wr(8'h91); wr(8'h92); wr(8'h93);
    eof(1'b0);
    check("drop_next_ready", 32'(Ready), 32'd1);
    rd(8'h91);
    check("drop_next_done", 32'(Ready), 32'd0);
`endif

    tick(); tick();
    check("size_queue_drained", 32'(q_size.size()), 32'd0);
    check("data_queue_drained", 32'(q_data.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
